// File: rtl/ip_checksum_arbiter.sv
// Round-robin front end that shares one fixed-latency checksum pipeline among
// N_REQ header builders and returns each result tagged with its requester ID.
module ip_checksum_arbiter #(
   parameter int N_REQ        = 4,
   parameter int ID_W         = 3,
   parameter int CSUM_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [16*N_REQ-1:0]   req_pkt_len,
   input  logic [32*N_REQ-1:0]   req_src_ip,
   input  logic [32*N_REQ-1:0]   req_dst_ip,
   output logic [N_REQ-1:0]      req_ready,
   output logic [15:0]           cs_pkt_len,
   output logic [31:0]           cs_src_ip,
   output logic [31:0]           cs_dst_ip,
   input  logic [15:0]           cs_checksum,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [15:0]           rsp_checksum,
   output logic                  busy
);

   localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

   logic [ID_W-1:0]  rr_ptr;
   logic [N_REQ-1:0] rot;
   logic             gnt_any;
   logic [ID_W-1:0]  gnt_off;
   logic [ID_W:0]    gnt_sum;
   logic [ID_W-1:0]  gnt_id;
   logic [ID_W:0]    ptr_inc;
   logic [ID_W-1:0]  ptr_nxt;

   logic            vld_p [CSUM_LATENCY+1];
   logic [ID_W-1:0] id_p  [CSUM_LATENCY+1];

   // Rotate requests so the pointer position lands at bit 0; the lowest set bit wins.
   always_comb begin
      rot     = N_REQ'({req_valid, req_valid} >> rr_ptr);
      gnt_any = 1'b0;
      gnt_off = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (rot[k]) begin
            gnt_any = 1'b1;
            gnt_off = ID_W'(k);
         end
      end
      if (rst) gnt_any = 1'b0;
      gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
      gnt_id  = (gnt_sum >= N_REQ_W) ? ID_W'(gnt_sum - N_REQ_W) : ID_W'(gnt_sum);
      ptr_inc = {1'b0, gnt_id} + (ID_W+1)'(1);
      ptr_nxt = (ptr_inc == N_REQ_W) ? '0 : ID_W'(ptr_inc);
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = gnt_any && (gnt_id == ID_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= '0;
         cs_pkt_len   <= '0;
         cs_src_ip    <= '0;
         cs_dst_ip    <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_checksum <= '0;
         for (int k = 0; k <= CSUM_LATENCY; k++) begin
            vld_p[k] <= 1'b0;
            id_p[k]  <= '0;
         end
      end else begin
         // p0: register the winner's fields onto the shared checksum inputs
         if (gnt_any) begin
            rr_ptr <= ptr_nxt;
            for (int i = 0; i < N_REQ; i++) begin
               if (req_ready[i]) begin
                  cs_pkt_len <= req_pkt_len[16*i +: 16];
                  cs_src_ip  <= req_src_ip[32*i +: 32];
                  cs_dst_ip  <= req_dst_ip[32*i +: 32];
               end
            end
         end
         vld_p[0] <= gnt_any;
         id_p[0]  <= gnt_id;
         // p1..pL: tag rides alongside the checksum unit's internal pipeline
         for (int k = 1; k <= CSUM_LATENCY; k++) begin
            vld_p[k] <= vld_p[k-1];
            id_p[k]  <= id_p[k-1];
         end
         // rsp: capture the result in the cycle its tag emerges
         rsp_valid <= vld_p[CSUM_LATENCY];
         if (vld_p[CSUM_LATENCY]) begin
            rsp_id       <= id_p[CSUM_LATENCY];
            rsp_checksum <= cs_checksum;
         end
      end
   end

   always_comb begin
      busy = rsp_valid;
      for (int k = 0; k <= CSUM_LATENCY; k++) begin
         busy = busy | vld_p[k];
      end
   end

endmodule

// File: tb/tb_ip_checksum_arbiter.sv
// Directed bench for ip_checksum_arbiter with a reference arbiter model and a
// response scoreboard; the checksum unit is stubbed as ~pkt_len delayed 4 cycles.
module tb_ip_checksum_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 3;
   localparam int LAT   = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [N_REQ-1:0]    req_valid;
   logic [16*N_REQ-1:0] req_pkt_len;
   logic [32*N_REQ-1:0] req_src_ip;
   logic [32*N_REQ-1:0] req_dst_ip;
   logic [N_REQ-1:0]    req_ready;
   logic [15:0]         cs_pkt_len;
   logic [31:0]         cs_src_ip;
   logic [31:0]         cs_dst_ip;
   logic [15:0]         cs_checksum;
   logic                rsp_valid;
   logic [ID_W-1:0]     rsp_id;
   logic [15:0]         rsp_checksum;
   logic                busy;

   always #5 clk = ~clk;

   ip_checksum_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .CSUM_LATENCY(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_pkt_len  (req_pkt_len),
      .req_src_ip   (req_src_ip),
      .req_dst_ip   (req_dst_ip),
      .req_ready    (req_ready),
      .cs_pkt_len   (cs_pkt_len),
      .cs_src_ip    (cs_src_ip),
      .cs_dst_ip    (cs_dst_ip),
      .cs_checksum  (cs_checksum),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_checksum (rsp_checksum),
      .busy         (busy)
   );

   logic [15:0] stub [LAT];
   always_ff @(posedge clk) begin
      stub[0] <= ~cs_pkt_len;
      for (int k = 1; k < LAT; k++) stub[k] <= stub[k-1];
   end
   assign cs_checksum = stub[LAT-1];

   typedef struct {
      int              due;
      int              gcyc;
      logic [ID_W-1:0] id;
      logic [15:0]     csum;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          ref_ptr = 0;
   logic [15:0] exp_len = '0;
   logic [31:0] exp_src = '0;
   logic [31:0] exp_dst = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      logic [N_REQ-1:0] exp_rdy;
      logic             exp_busy;
      logic             exp_rv;
      int               win;
      exp_t             e;
      @(negedge clk);
      exp_rdy = '0;
      win     = -1;
      if (!rst) begin
         for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (ref_ptr + k) % N_REQ;
            if (win < 0 && req_valid[i]) win = i;
         end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("cs_pkt_len", 32'(cs_pkt_len), 32'(exp_len));
      check("cs_src_ip", cs_src_ip, exp_src);
      check("cs_dst_ip", cs_dst_ip, exp_dst);
      exp_busy = 1'b0;
      foreach (sb[j]) if (sb[j].gcyc < cyc) exp_busy = 1'b1;
      check("busy", 32'(busy), 32'(exp_busy));
      exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         e = sb.pop_front();
         check("rsp_id", 32'(rsp_id), 32'(e.id));
         check("rsp_checksum", 32'(rsp_checksum), 32'(e.csum));
      end
      @(posedge clk);
      if (rst) begin
         sb.delete();
         ref_ptr = 0;
         exp_len = '0;
         exp_src = '0;
         exp_dst = '0;
      end else if (win >= 0) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (i == win) begin
               exp_len = req_pkt_len[16*i +: 16];
               exp_src = req_src_ip[32*i +: 32];
               exp_dst = req_dst_ip[32*i +: 32];
            end
         end
         e.due  = cyc + 2 + LAT;
         e.gcyc = cyc;
         e.id   = ID_W'(win);
         e.csum = ~exp_len;
         sb.push_back(e);
         ref_ptr = (win + 1) % N_REQ;
      end
      #1;
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int s = 0; s < n; s++) step();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_pkt_len[16*i +: 16] = 16'(16'h0100 + i);
         req_src_ip[32*i +: 32]  = 32'h0A00_0000 + 32'(i);
         req_dst_ip[32*i +: 32]  = 32'hC0A8_0000 + 32'(i * 17);
      end
      steps(2);
      rst = 1'b0;

      // single request: grant in cycle 0, response FFCF for id 0 in cycle 6
      req_pkt_len[15:0] = 16'h0030;
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0000;
      steps(8);

      // all four requesting continuously from pointer 0
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_pkt_len[15:0] = 16'h0100;
      req_valid = 4'b1111;
      steps(8);
      req_valid = 4'b0000;
      steps(7);

      // pointer wrap: 3, then 0 and 3 again
      req_valid = 4'b1000;
      step();
      req_valid = 4'b1001;
      step();
      req_valid = 4'b1000;
      step();
      req_valid = 4'b0000;
      steps(7);

      // priority hold: move pointer to 2, then 2 beats 1
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0110;
      step();
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      steps(7);

      // reset mid-flight with requests still asserted
      req_valid = 4'b0111;
      steps(3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 4'b0000;
      steps(7);
      req_pkt_len[15:0] = 16'h1234;
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0000;
      steps(7);

      for (int s = 0; s < 20 && sb.size() > 0; s++) step();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
